// File: rtl/eae_sequencer.sv
// eae_sequencer: multi-cycle extended-arithmetic unit (MUY, DVI, NMI, SHL)
// working on {LINK, AC, MQ}, one iteration per clock, with a level
// eae_start / eae_fin handshake toward the main controller.
module eae_sequencer #(
  parameter int WIDTH = 12,
  parameter int SCW   = 5
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             eae_start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] mq_in,
  input  logic             link_in,
  input  logic [WIDTH-1:0] operand_in,
  output logic [WIDTH-1:0] ac_out,
  output logic [WIDTH-1:0] mq_out,
  output logic             link_out,
  output logic [SCW-1:0]   sc_out,
  output logic             busy,
  output logic             eae_fin
);

  // Internal counter is wide enough for WIDTH, for the longest NMI run
  // (about 2*WIDTH shifts) and for an SHL count of 2**SCW.
  localparam int CW_ITER = $clog2(2 * WIDTH + 1);
  localparam int CW      = (CW_ITER > SCW + 1) ? CW_ITER : SCW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] OP_MUY = 2'b00;
  localparam logic [1:0] OP_DVI = 2'b01;
  localparam logic [1:0] OP_NMI = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    DIV   = 3'd3,
    NORM  = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic             l;
  logic [WIDTH-1:0] y;
  logic [1:0]       op;
  logic [CW-1:0]    cnt;

  // NMI stops once the top two AC bits differ or nothing below the sign is left.
  function automatic logic nmi_stop(input logic [WIDTH-1:0] a_v,
                                    input logic [WIDTH-1:0] q_v);
    return (a_v[WIDTH-1] != a_v[WIDTH-2]) ||
           ({a_v[WIDTH-2:0], q_v} == {(2*WIDTH-1){1'b0}});
  endfunction

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] shl_a;
  logic [WIDTH-1:0] shl_q;

  // Next-iteration datapath values for every operation.
  always_comb begin
    mul_sum  = {1'b0, a} + (q[0] ? {1'b0, y} : {(WIDTH+1){1'b0}});
    div_rem  = {a, q[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, y});
    div_diff = div_rem[WIDTH-1:0] - y;  // remainder < Y, so it fits in WIDTH bits
    shl_a    = {a[WIDTH-2:0], q[WIDTH-1]};
    shl_q    = {q[WIDTH-2:0], 1'b0};
  end

  assign ac_out   = a;
  assign mq_out   = q;
  assign link_out = l;
  assign sc_out   = cnt[SCW-1:0];

  // Sequencer FSM with working registers and registered handshake outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      a       <= {WIDTH{1'b0}};
      q       <= {WIDTH{1'b0}};
      l       <= 1'b0;
      y       <= {WIDTH{1'b0}};
      op      <= 2'b00;
      cnt     <= {CW{1'b0}};
      busy    <= 1'b0;
      eae_fin <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          eae_fin <= 1'b0;
          if (eae_start) begin
            state <= LOAD;
            busy  <= 1'b1;
            a     <= ac_in;
            q     <= mq_in;
            l     <= link_in;
            y     <= operand_in;
            op    <= mode;
            case (mode)
              OP_MUY:  cnt <= CW'(WIDTH);
              OP_DVI:  cnt <= CW'(WIDTH);
              OP_NMI:  cnt <= {CW{1'b0}};
              OP_SHL:  cnt <= CW'(operand_in[SCW-1:0]) + CNT_ONE;
              default: cnt <= {CW{1'b0}};
            endcase
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          case (op)
            OP_MUY: begin
              l     <= 1'b0;
              state <= MUL;
            end
            OP_DVI: begin
              if (a >= y) begin
                l       <= 1'b1;
                state   <= DONE;
                busy    <= 1'b0;
                eae_fin <= 1'b1;
              end else begin
                l     <= 1'b0;
                state <= DIV;
              end
            end
            OP_NMI: begin
              if (nmi_stop(a, q)) begin
                state   <= DONE;
                busy    <= 1'b0;
                eae_fin <= 1'b1;
              end else begin
                state <= NORM;
              end
            end
            OP_SHL:  state <= SHIFT;
            default: begin
              state   <= DONE;
              busy    <= 1'b0;
              eae_fin <= 1'b1;
            end
          endcase
        end
        MUL: begin
          a   <= mul_sum[WIDTH:1];
          q   <= {mul_sum[0], q[WIDTH-1:1]};
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= DONE;
            busy    <= 1'b0;
            eae_fin <= 1'b1;
          end
        end
        DIV: begin
          a   <= div_ge ? div_diff : div_rem[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], div_ge};
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= DONE;
            busy    <= 1'b0;
            eae_fin <= 1'b1;
          end
        end
        NORM: begin
          a   <= shl_a;
          q   <= shl_q;
          cnt <= cnt + CNT_ONE;
          if (nmi_stop(shl_a, shl_q)) begin
            state   <= DONE;
            busy    <= 1'b0;
            eae_fin <= 1'b1;
          end
        end
        SHIFT: begin
          l   <= a[WIDTH-1];
          a   <= shl_a;
          q   <= shl_q;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= DONE;
            busy    <= 1'b0;
            eae_fin <= 1'b1;
          end
        end
        DONE: begin
          busy <= 1'b0;
          if (eae_start) begin
            eae_fin <= 1'b1;
          end else begin
            state   <= IDLE;
            eae_fin <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          eae_fin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eae_sequencer.sv
// Table-driven bench for eae_sequencer at WIDTH = 12 (values in octal).
module tb_eae_sequencer;

  logic        clock;
  logic        resetN;
  logic        eae_start;
  logic [1:0]  mode;
  logic [11:0] ac_in;
  logic [11:0] mq_in;
  logic        link_in;
  logic [11:0] operand_in;
  logic [11:0] ac_out;
  logic [11:0] mq_out;
  logic        link_out;
  logic [4:0]  sc_out;
  logic        busy;
  logic        eae_fin;

  int n_vec;
  int n_err;

  eae_sequencer #(.WIDTH(12), .SCW(5)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .eae_start  (eae_start),
    .mode       (mode),
    .ac_in      (ac_in),
    .mq_in      (mq_in),
    .link_in    (link_in),
    .operand_in (operand_in),
    .ac_out     (ac_out),
    .mq_out     (mq_out),
    .link_out   (link_out),
    .sc_out     (sc_out),
    .busy       (busy),
    .eae_fin    (eae_fin)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  md;
    logic [11:0] ac;
    logic [11:0] mq;
    logic        lk;
    logic [11:0] y;
    logic [11:0] e_ac;
    logic [11:0] e_mq;
    logic        e_lk;
    logic [4:0]  e_sc;
    int          e_cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o, expected %0o", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] md,
                              input logic [11:0] ac, input logic [11:0] mq,
                              input logic lk, input logic [11:0] y,
                              input logic [11:0] e_ac, input logic [11:0] e_mq,
                              input logic e_lk, input logic [4:0] e_sc,
                              input int e_cyc);
    vec_t v;
    v.name = nm; v.md = md; v.ac = ac; v.mq = mq; v.lk = lk; v.y = y;
    v.e_ac = e_ac; v.e_mq = e_mq; v.e_lk = e_lk; v.e_sc = e_sc; v.e_cyc = e_cyc;
    return v;
  endfunction

  // Start one operation, count edges to eae_fin, check result, hold and release.
  task automatic run_op(input vec_t v);
    int n;
    @(negedge clock);
    mode = v.md; ac_in = v.ac; mq_in = v.mq; link_in = v.lk; operand_in = v.y;
    eae_start = 1'b1;
    @(posedge clock);
    #1;
    chk({v.name, ".busy_load"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (eae_fin !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({v.name, ".cycles"}, n, v.e_cyc);
    chk({v.name, ".ac"}, {20'd0, ac_out}, {20'd0, v.e_ac});
    chk({v.name, ".mq"}, {20'd0, mq_out}, {20'd0, v.e_mq});
    chk({v.name, ".link"}, {31'd0, link_out}, {31'd0, v.e_lk});
    chk({v.name, ".sc"}, {27'd0, sc_out}, {27'd0, v.e_sc});
    // keep eae_start high: must stay in DONE without restarting
    @(posedge clock);
    @(posedge clock);
    #1;
    chk({v.name, ".fin_hold"}, {31'd0, eae_fin}, 32'd1);
    chk({v.name, ".busy_hold"}, {31'd0, busy}, 32'd0);
    chk({v.name, ".ac_hold"}, {20'd0, ac_out}, {20'd0, v.e_ac});
    @(negedge clock);
    eae_start = 1'b0;
    ac_in = ~v.ac; mq_in = ~v.mq; operand_in = ~v.y;
    @(posedge clock);
    #1;
    chk({v.name, ".fin_drop"}, {31'd0, eae_fin}, 32'd0);
    chk({v.name, ".mq_idle"}, {20'd0, mq_out}, {20'd0, v.e_mq});
    @(posedge clock);
    #1;
    chk({v.name, ".ac_idle"}, {20'd0, ac_out}, {20'd0, v.e_ac});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // name, mode, ac, mq, link, y | ac, mq, link, sc, cycles start->fin
    vecs[0]  = mk("muy_small", 2'b00, 12'o0000, 12'o0012, 1'b1, 12'o0003, 12'o0000, 12'o0036, 1'b0, 5'd0, 13);
    vecs[1]  = mk("muy_max",   2'b00, 12'o7777, 12'o7777, 1'b0, 12'o7777, 12'o7777, 12'o0000, 1'b0, 5'd0, 13);
    vecs[2]  = mk("muy_add",   2'b00, 12'o0100, 12'o0005, 1'b0, 12'o0010, 12'o0000, 12'o0150, 1'b0, 5'd0, 13);
    vecs[3]  = mk("dvi",       2'b01, 12'o0000, 12'o0144, 1'b1, 12'o0007, 12'o0002, 12'o0016, 1'b0, 5'd0, 13);
    vecs[4]  = mk("dvi_ovf",   2'b01, 12'o0005, 12'o0144, 1'b0, 12'o0005, 12'o0005, 12'o0144, 1'b1, 5'd12, 1);
    vecs[5]  = mk("dvi_zero",  2'b01, 12'o0003, 12'o0001, 1'b0, 12'o0000, 12'o0003, 12'o0001, 1'b1, 5'd12, 1);
    vecs[6]  = mk("dvi_big",   2'b01, 12'o0001, 12'o0000, 1'b0, 12'o0002, 12'o0000, 12'o4000, 1'b0, 5'd0, 13);
    vecs[7]  = mk("nmi",       2'b10, 12'o0001, 12'o0000, 1'b1, 12'o0000, 12'o2000, 12'o0000, 1'b1, 5'd10, 11);
    vecs[8]  = mk("nmi_zero",  2'b10, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000, 12'o0000, 1'b0, 5'd0, 1);
    vecs[9]  = mk("nmi_norm",  2'b10, 12'o4000, 12'o0000, 1'b1, 12'o0000, 12'o4000, 12'o0000, 1'b1, 5'd0, 1);
    vecs[10] = mk("nmi_mq",    2'b10, 12'o0000, 12'o0001, 1'b0, 12'o0000, 12'o2000, 12'o0000, 1'b0, 5'd22, 23);
    vecs[11] = mk("nmi_neg",   2'b10, 12'o7777, 12'o7777, 1'b0, 12'o0000, 12'o4000, 12'o0000, 1'b0, 5'd23, 24);
    vecs[12] = mk("shl",       2'b11, 12'o4001, 12'o4000, 1'b0, 12'o0000, 12'o0003, 12'o0000, 1'b1, 5'd0, 2);
    vecs[13] = mk("shl4",      2'b11, 12'o0001, 12'o0000, 1'b1, 12'o0003, 12'o0020, 12'o0000, 1'b0, 5'd0, 5);

    resetN = 1'b0; eae_start = 1'b0; mode = 2'b00;
    ac_in = 12'o0000; mq_in = 12'o0000; link_in = 1'b0; operand_in = 12'o0000;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.ac", {20'd0, ac_out}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.fin", {31'd0, eae_fin}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i]);
    end

    // Reset in cycle 5 of a MUY: everything clears, then a new op still works.
    @(negedge clock);
    mode = 2'b00; ac_in = 12'o7777; mq_in = 12'o7777; link_in = 1'b1; operand_in = 12'o7777;
    eae_start = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    chk("abort.ac", {20'd0, ac_out}, 32'd0);
    chk("abort.mq", {20'd0, mq_out}, 32'd0);
    chk("abort.link", {31'd0, link_out}, 32'd0);
    chk("abort.sc", {27'd0, sc_out}, 32'd0);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.fin", {31'd0, eae_fin}, 32'd0);
    eae_start = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
    chk("abort.idle_busy", {31'd0, busy}, 32'd0);
    run_op(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eae_sequencer.md
# eae_sequencer

Parametrised extended-arithmetic sequencer for the PDP-8 CPU. It executes MUY, DVI, NMI and SHL as multi-cycle operations on the {LINK, AC, MQ} registers, one iteration per clock. It sits beside the main controller and is driven through the level `eae_start` / `eae_fin` handshake that the controller's EAE states use. Word width is a parameter: 12 for the PDP-8, and wider for future variants.

## Interface
- `WIDTH`, default 12: data word width in bits; must be ≥ 4.
- `SCW`, default 5: width of the shift-count field and of `sc_out`.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `eae_start`  in  1  level request. Sampled only in IDLE.
- `mode`  in  2  operation: 00 MUY, 01 DVI, 10 NMI, 11 SHL. Latched at start.
- `ac_in`  in  WIDTH  accumulator operand. Latched at start.
- `mq_in`  in  WIDTH  MQ operand. Latched at start.
- `link_in`  in  1  link operand. Latched at start.
- `operand_in`  in  WIDTH  memory word Y. It is the multiplier or divisor, or its low SCW bits are the SHL count. Latched at start.
- `ac_out`  out  WIDTH  result AC.
- `mq_out`  out  WIDTH  result MQ.
- `link_out`  out  1  result link.
- `sc_out`  out  SCW  step counter. For NMI it holds the shift count.
- `busy`  out  1  high in LOAD and in every iteration state.
- `eae_fin`  out  1  high in DONE only.

## Operation
- **States**
  - IDLE: go to LOAD when `eae_start` is 1.
  - LOAD: go to MUL, DIV, NORM, SHIFT or DONE.
  - Iteration states: go to DONE when the termination condition is met.
  - DONE: stay while `eae_start` is 1; go to IDLE when `eae_start` is 0.
- **LOAD actions**
  - Latch all inputs into working registers A, Q, L.
  - Set the counter: WIDTH for MUY and DVI; 0 for NMI; `operand_in[SCW-1:0]` + 1 for SHL.
- **MUY**
  - {A,Q} = Q × Y + A, by shift-add, one multiplier bit per cycle, WIDTH cycles.
  - L = 0.
  - The result always fits in 2·WIDTH bits, so overflow cannot occur.
- **DVI**
  - Overflow check in LOAD: if A ≥ Y (this includes Y = 0), set L = 1, leave A and Q unchanged, and go straight to DONE.
  - Otherwise run a restoring divide for WIDTH cycles.
  - Result: Q = quotient of {A,Q}/Y, A = remainder, L = 0.
- **NMI**
  - Each cycle, shift {A,Q} left by 1, insert 0 at the Q lsb, and increment SC.
  - Stop when A[W-1] ≠ A[W-2], or when {A[W-2:0],Q} == 0.
  - The stop condition is evaluated in LOAD first, so zero shifts is possible.
  - L passes through unchanged.
- **SHL**
  - Each cycle, shift {L,A,Q} left by 1, insert 0 at the Q lsb, and decrement SC.
  - Stop when SC reaches 0. SC ends at 0.
- **Outputs and inputs**
  - Outputs are registered from A, Q, L and SC, and are updated every cycle.
  - In DONE and IDLE the outputs hold the final result until the next LOAD.
  - Inputs are ignored outside IDLE. A start request while busy is not queued.

## Timing
- Reset, asynchronous: state returns to IDLE, and every output becomes 0 (`ac_out`, `mq_out`, `link_out`, `sc_out`, `busy`, `eae_fin`).
- Reset mid-operation aborts the operation with no partial result kept.
- Edge k samples `eae_start` = 1 in IDLE and enters LOAD. Edge k+1+N enters DONE, where N is the iteration count:
  - MUY: N = WIDTH.
  - DVI, no overflow: N = WIDTH.
  - DVI overflow: N = 0.
  - NMI: N = number of shifts.
  - SHL: N = count + 1.
- For WIDTH = 12, MUY raises `eae_fin` 13 cycles after the start edge.
- `eae_fin` is high for at least one cycle. It stays high until the first edge that samples `eae_start` = 0, and falls at that edge.
- Results are valid from the DONE entry edge and remain stable through the following IDLE cycles. The controller samples them in the cycle after it drops `eae_start`.
- A back-to-back operation needs at least one IDLE cycle with `eae_start` = 0.

## Test plan
All cases use WIDTH = 12; values are octal.
- **MUY small:** AC=0000, MQ=0012, Y=0003 → AC=0000, MQ=0036, L=0; `eae_fin` 13 cycles after start.
- **MUY maximum:** AC=7777, MQ=7777, Y=7777 → AC=7777, MQ=0000, L=0.
- **DVI:** AC=0000, MQ=0144, Y=0007 → MQ=0016, AC=0002, L=0. Then AC=0005, Y=0005 (overflow) → L=1, AC and MQ unchanged, `eae_fin` 1 cycle after start. Y=0000 also gives overflow.
- **NMI:** AC=0001, MQ=0000, L=1 → AC=2000, MQ=0000, SC=12 (ten shifts), L=1. Then AC=0000, MQ=0000 → zero shifts, SC=0.
- **SHL:** L=0, AC=4001, MQ=4000, Y=0000 → L=1, AC=0003, MQ=0000, SC=0.
- **Reset and handshake:**
  - Assert `resetN`=0 in cycle 5 of an MUY → all outputs 0, state IDLE.
  - Hold `eae_start` high after DONE → `eae_fin` stays 1 and no restart occurs.
  - Drop `eae_start` → IDLE next edge, results still held.
